// File: rtl/tranceiver_rx.sv
// ASCII move-string parser: "<col><row><tile>\n" -> {col, row, tile} with one-cycle valid/error pulses.
// Define TRANCEIVER_RX_ERR_EN to enable the move_error pulse (otherwise it is tied low).
module tranceiver_rx (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  output logic [21:0] move_out,
  output logic        move_valid,
  output logic        move_error
);

`ifdef TRANCEIVER_RX_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    s_IDLE,
    s_COL,
    s_ROW,
    s_EOL,
    s_DISCARD
  } state_t;

  state_t      state, state_n;
  logic [9:0]  col, col_n;
  logic [9:0]  row, row_n;
  logic [1:0]  tile, tile_n;
  logic [1:0]  col_cnt, col_cnt_n;
  logic [1:0]  row_cnt, row_cnt_n;
  logic [21:0] move_out_n;
  logic        valid_n;
  logic        err_n;

  logic        is_col, is_letter, is_digit, is_lf, is_cr, is_tile;
  logic [1:0]  tile_code;
  logic [4:0]  letter_val;
  logic [3:0]  digit_val;
  logic [9:0]  col_acc;
  logic [9:0]  row_acc;

  assign is_col     = (rx_byte >= 8'h40) && (rx_byte <= 8'h5A);
  assign is_letter  = (rx_byte >= 8'h41) && (rx_byte <= 8'h5A);
  assign is_digit   = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign is_lf      = (rx_byte == 8'h0A);
  assign is_cr      = (rx_byte == 8'h0D);
  assign is_tile    = (rx_byte == 8'h2B) || (rx_byte == 8'h2F) || (rx_byte == 8'h5C);
  assign tile_code  = (rx_byte == 8'h2F) ? 2'b01 : (rx_byte == 8'h5C) ? 2'b10 : 2'b00;
  // '@'..'Z' map to 0..26 through their low five bits
  assign letter_val = rx_byte[4:0];
  assign digit_val  = rx_byte[3:0];
  assign col_acc    = (col * 10'd26) + {5'd0, letter_val};
  assign row_acc    = (row * 10'd10) + {6'd0, digit_val};

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= s_IDLE;
      col        <= '0;
      row        <= '0;
      tile       <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      move_out   <= '0;
      move_valid <= 1'b0;
      move_error <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      tile       <= tile_n;
      col_cnt    <= col_cnt_n;
      row_cnt    <= row_cnt_n;
      move_out   <= move_out_n;
      move_valid <= valid_n;
      move_error <= err_n;
    end
  end

  always_comb begin
    logic bad;
    state_n    = state;
    col_n      = col;
    row_n      = row;
    tile_n     = tile;
    col_cnt_n  = col_cnt;
    row_cnt_n  = row_cnt;
    move_out_n = move_out;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    bad        = 1'b0;

    if (rx_done) begin
      unique case (state)
        s_IDLE: begin
          if (is_col) begin
            col_n     = {5'd0, letter_val};
            col_cnt_n = 2'd1;
            state_n   = s_COL;
          end else if (!(is_lf || is_cr)) begin
            bad = 1'b1;
          end
        end
        s_COL: begin
          // a leading '@' (col==0) cannot take a second letter
          if (is_letter && (col_cnt == 2'd1) && (col != 10'd0)) begin
            col_n     = col_acc;
            col_cnt_n = 2'd2;
          end else if (is_digit) begin
            row_n     = {6'd0, digit_val};
            row_cnt_n = 2'd1;
            state_n   = s_ROW;
          end else begin
            bad = 1'b1;
          end
        end
        s_ROW: begin
          if (is_digit && (row_cnt < 2'd3)) begin
            row_n     = row_acc;
            row_cnt_n = row_cnt + 2'd1;
          end else if (is_tile) begin
            tile_n  = tile_code;
            state_n = s_EOL;
          end else begin
            bad = 1'b1;
          end
        end
        s_EOL: begin
          if (is_lf) begin
            move_out_n = {col, row, tile};
            valid_n    = 1'b1;
            state_n    = s_IDLE;
          end else if (!is_cr) begin
            bad = 1'b1;
          end
        end
        s_DISCARD: begin
          if (is_lf) state_n = s_IDLE;
        end
        default: state_n = s_IDLE;
      endcase

      // an offending LF already terminates the string, so skip discard
      if (bad) begin
        err_n   = ERR_EN;
        state_n = is_lf ? s_IDLE : s_DISCARD;
      end
    end
  end

endmodule

// File: tb/tb_tranceiver_rx.sv
// Directed bench for tranceiver_rx: valid strings, malformed strings, back-to-back bytes and reset.
module tb_tranceiver_rx;

`ifdef TRANCEIVER_RX_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_done = 1'b0;
  logic [21:0] move_out;
  logic        move_valid;
  logic        move_error;

  int n_cmp = 0;
  int n_bad = 0;
  logic [21:0] exp_out;

  tranceiver_rx dut (
    .clock      (clock),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_done    (rx_done),
    .move_out   (move_out),
    .move_valid (move_valid),
    .move_error (move_error)
  );

  always #5 clock = ~clock;

  // Sends a string one byte per strobe with an idle cycle between bytes; counts pulses at every sample.
  task automatic send_str(input string s, output int nv, output int ne, output int eidx, output int both);
    nv = 0; ne = 0; eidx = -1; both = 0;
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clock);
      if (move_valid) nv++;
      if (move_error) ne++;
      if (move_valid && move_error) both++;
      rx_byte = s[i];
      rx_done = 1'b1;
      @(negedge clock);
      rx_done = 1'b0;
      if (move_valid) nv++;
      if (move_error) begin ne++; if (eidx < 0) eidx = i; end
      if (move_valid && move_error) both++;
    end
    @(negedge clock);
    if (move_valid) nv++;
    if (move_error) ne++;
    if (move_valid && move_error) both++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_done = 1'b1;
    rx_byte = 8'h41;
    repeat (3) @(negedge clock);
    n_cmp++; if (move_out !== 22'd0) begin n_bad++; $display("FAIL reset_out: got %h want %h", move_out, 22'd0); end
    n_cmp++; if (move_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", move_valid); end
    n_cmp++; if (move_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", move_error); end
    reset = 1'b0;
    rx_done = 1'b0;
    exp_out = 22'd0;
  endtask

  task automatic test_valid_moves();
    int nv, ne, ei, bo;
    send_str("A1+\n", nv, ne, ei, bo);
    exp_out = 22'h001004;
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL a1_valid_cnt: got %0d want 1", nv); end
    n_cmp++; if (ne !== 0) begin n_bad++; $display("FAIL a1_error_cnt: got %0d want 0", ne); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL a1_out: got %h want %h", move_out, exp_out); end

    send_str("@0/\r\n", nv, ne, ei, bo);
    exp_out = 22'h000001;
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL at0_valid_cnt: got %0d want 1", nv); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL at0_out: got %h want %h", move_out, exp_out); end

    send_str("ZZ999\\\n", nv, ne, ei, bo);
    exp_out = {10'd702, 10'd999, 2'b10};
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL zz_valid_cnt: got %0d want 1", nv); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL zz_out: got %h want %h", move_out, exp_out); end

    send_str("\r\nAB1+\n", nv, ne, ei, bo);
    exp_out = {10'd28, 10'd1, 2'b00};
    n_cmp++; if (nv !== 1 || ne !== 0) begin n_bad++; $display("FAIL ab_cnt: got v%0d e%0d want v1 e0", nv, ne); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL ab_out: got %h want %h", move_out, exp_out); end

    send_str("A007+\n", nv, ne, ei, bo);
    exp_out = {10'd1, 10'd7, 2'b00};
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL lead0_out: got %h want %h", move_out, exp_out); end
  endtask

  task automatic test_errors();
    int nv, ne, ei, bo;
    send_str("A1234+\n", nv, ne, ei, bo);
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL row4_valid_cnt: got %0d want 0", nv); end
    n_cmp++; if (ne !== ERR_EN) begin n_bad++; $display("FAIL row4_error_cnt: got %0d want %0d", ne, ERR_EN); end
    n_cmp++; if (ei !== (ERR_EN != 0 ? 4 : -1)) begin n_bad++; $display("FAIL row4_error_pos: got %0d want %0d", ei, (ERR_EN != 0 ? 4 : -1)); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL row4_out_held: got %h want %h", move_out, exp_out); end

    send_str("B2/\n", nv, ne, ei, bo);
    exp_out = {10'd2, 10'd2, 2'b01};
    n_cmp++; if (nv !== 1 || ne !== 0) begin n_bad++; $display("FAIL b2_cnt: got v%0d e%0d want v1 e0", nv, ne); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL b2_out: got %h want %h", move_out, exp_out); end

    send_str("@A1+\n", nv, ne, ei, bo);
    n_cmp++; if (nv !== 0 || ei !== (ERR_EN != 0 ? 1 : -1)) begin n_bad++; $display("FAIL at_letter: got v%0d pos%0d want v0 pos%0d", nv, ei, (ERR_EN != 0 ? 1 : -1)); end

    send_str("ABC1+\n", nv, ne, ei, bo);
    n_cmp++; if (nv !== 0 || ei !== (ERR_EN != 0 ? 2 : -1)) begin n_bad++; $display("FAIL three_letters: got v%0d pos%0d want v0 pos%0d", nv, ei, (ERR_EN != 0 ? 2 : -1)); end

    send_str("A1x\n", nv, ne, ei, bo);
    n_cmp++; if (nv !== 0 || ei !== (ERR_EN != 0 ? 2 : -1)) begin n_bad++; $display("FAIL bad_tile: got v%0d pos%0d want v0 pos%0d", nv, ei, (ERR_EN != 0 ? 2 : -1)); end
    n_cmp++; if (bo !== 0) begin n_bad++; $display("FAIL bad_tile_both: got %0d want 0", bo); end

    send_str("5\n", nv, ne, ei, bo);
    n_cmp++; if (nv !== 0 || ne !== ERR_EN || ei !== (ERR_EN != 0 ? 0 : -1)) begin n_bad++; $display("FAIL idle_digit: got v%0d e%0d pos%0d want v0 e%0d", nv, ne, ei, ERR_EN); end

    // the LF that raises the error also ends the string; next string parses cleanly
    send_str("A\n", nv, ne, ei, bo);
    n_cmp++; if (nv !== 0 || ne !== ERR_EN || ei !== (ERR_EN != 0 ? 1 : -1)) begin n_bad++; $display("FAIL err_on_lf: got v%0d e%0d pos%0d want v0 e%0d", nv, ne, ei, ERR_EN); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL err_out_held: got %h want %h", move_out, exp_out); end
    send_str("C7\\\n", nv, ne, ei, bo);
    exp_out = {10'd3, 10'd7, 2'b10};
    n_cmp++; if (nv !== 1 || ne !== 0 || move_out !== exp_out) begin n_bad++; $display("FAIL after_lf_err: got v%0d e%0d out %h want v1 e0 out %h", nv, ne, move_out, exp_out); end
  endtask

  task automatic test_rx_done_gating();
    int nv, ne, ei, bo;
    send_str("E", nv, ne, ei, bo);
    rx_byte = 8'h0A;
    rx_done = 1'b0;
    repeat (4) @(negedge clock);
    send_str("5+\n", nv, ne, ei, bo);
    exp_out = {10'd5, 10'd5, 2'b00};
    n_cmp++; if (nv !== 1 || ne !== 0 || move_out !== exp_out) begin n_bad++; $display("FAIL gating: got v%0d e%0d out %h want v1 e0 out %h", nv, ne, move_out, exp_out); end
  endtask

  task automatic test_back_to_back();
    string s;
    int nv, vpos;
    logic [7:0] b;
    s = "\r\nD4+\n";
    nv = 0; vpos = -1;
    @(negedge clock);
    rx_done = 1'b1;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      rx_byte = b;
      @(negedge clock);
      if (move_valid) begin nv++; vpos = i; end
    end
    rx_done = 1'b0;
    @(negedge clock);
    if (move_valid) nv++;
    exp_out = {10'd4, 10'd4, 2'b00};
    n_cmp++; if (nv !== 1 || vpos !== 5) begin n_bad++; $display("FAIL b2b_valid: got cnt%0d pos%0d want cnt1 pos5", nv, vpos); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL b2b_out: got %h want %h", move_out, exp_out); end
  endtask

  task automatic test_reset_midstring();
    int nv, ne, ei, bo;
    send_str("A1", nv, ne, ei, bo);
    @(negedge clock);
    reset = 1'b1;
    rx_byte = 8'h2B;
    rx_done = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rx_done = 1'b0;
    n_cmp++; if (move_valid !== 1'b0 || move_error !== 1'b0 || move_out !== 22'd0) begin n_bad++; $display("FAIL mid_reset: got v%b e%b out %h want v0 e0 out 0", move_valid, move_error, move_out); end
    send_str("C3+\n", nv, ne, ei, bo);
    exp_out = {10'd3, 10'd3, 2'b00};
    n_cmp++; if (nv !== 1 || ne !== 0) begin n_bad++; $display("FAIL c3_cnt: got v%0d e%0d want v1 e0", nv, ne); end
    n_cmp++; if (move_out !== exp_out) begin n_bad++; $display("FAIL c3_out: got %h want %h", move_out, exp_out); end
  endtask

  initial begin
    test_reset();
    test_valid_moves();
    test_errors();
    test_rx_done_gating();
    test_back_to_back();
    test_reset_midstring();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
